// File: rtl/hilo_sequencer.sv
// HI/LO sequencer: 32-step shift-add MULTU and restoring DIV/DIVU, plus MTHI/MTLO.
// One 64-bit accumulator serves as {hi,lo} product for multiply and {rem,quo} for divide.
module hilo_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        MULTU,
  input  logic        DIV,
  input  logic        DIVU,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic [31:0] rsdata,
  input  logic [31:0] rtdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e      state_q;
  logic [31:0] hi_q, lo_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;       // multiplicand or divisor magnitude
  logic        signed_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] rs_abs, rt_abs;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_diff[33]) begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
    rs_abs = rsdata[31] ? -rsdata : rsdata;
    rt_abs = rtdata[31] ? -rtdata : rtdata;
  end

  assign stall = ((state_q == S_IDLE) && (MULTU || DIV || DIVU)) ||
                 (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done  = (state_q == S_DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DIV || DIVU) begin
            if (rtdata == 32'd0) begin
              hi_q    <= rsdata;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
            end else begin
              signed_q  <= DIV;
              acc_q     <= {32'd0, DIV ? rs_abs : rsdata};
              opnd_q    <= DIV ? rt_abs : rtdata;
              neg_quo_q <= DIV & (rsdata[31] ^ rtdata[31]);
              neg_rem_q <= DIV & rsdata[31];
              cnt_q     <= 5'd31;
              state_q   <= S_DIV;
            end
          end else if (MULTU) begin
            acc_q   <= {32'd0, rtdata};
            opnd_q  <= rsdata;
            cnt_q   <= 5'd31;
            state_q <= S_MUL;
          end else if (MTHI) begin
            hi_q <= rsdata;
          end else if (MTLO) begin
            lo_q <= rsdata;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            hi_q    <= mul_next[63:32];
            lo_q    <= mul_next[31:0];
            state_q <= S_DONE;
          end
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            if (signed_q) begin
              state_q <= S_FIX;
            end else begin
              hi_q    <= div_next[63:32];
              lo_q    <= div_next[31:0];
              state_q <= S_DONE;
            end
          end
        end
        // Magnitudes wrap, so 0x80000000 / -1 lands on lo=0x80000000 without a trap.
        S_FIX: begin
          lo_q    <= neg_quo_q ? -acc_q[31:0]  : acc_q[31:0];
          hi_q    <= neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: directed cases plus randomized ops against
// an arithmetic reference model of HI/LO results and stall/done timing.
module tb_hilo_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        MULTU, DIV, DIVU, MTHI, MTLO;
  logic [31:0] rsdata, rtdata;
  logic        stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_DIVU  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b00100;
  localparam logic [4:0] OP_MTHI  = 5'b00010;
  localparam logic [4:0] OP_MTLO  = 5'b00001;

  hilo_sequencer dut (
    .clk(clk), .rst(rst),
    .MULTU(MULTU), .DIV(DIV), .DIVU(DIVU), .MTHI(MTHI), .MTLO(MTLO),
    .rsdata(rsdata), .rtdata(rtdata),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: applies priority, then plain arithmetic; st is the expected stall-cycle count.
  function automatic void model_op(input logic [4:0] ops, input logic [31:0] a, b,
                                   input logic [31:0] h, l,
                                   output logic [31:0] nh, nl, output int st);
    longint sa, sb, q, r;
    logic [63:0] p;
    nh = h; nl = l; st = 0;
    if (ops[4] || ops[3]) begin
      if (b == 32'd0) begin
        nh = a; nl = 32'hFFFF_FFFF; st = 1;
      end else if (ops[4]) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        nl = q[31:0]; nh = r[31:0]; st = 34;
      end else begin
        nl = a / b; nh = a % b; st = 33;
      end
    end else if (ops[2]) begin
      p = {32'd0, a} * {32'd0, b};
      nh = p[63:32]; nl = p[31:0]; st = 33;
    end else if (ops[1]) begin
      nh = a;
    end else if (ops[0]) begin
      nl = a;
    end
  endfunction

  // Drives one instruction, holding it until done (or a 40-cycle budget), measuring timing.
  task automatic run_op(input logic [4:0] ops, input logic [31:0] a, b,
                        output int stalls, output int done_cyc, output int dones,
                        output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    {DIV, DIVU, MULTU, MTHI, MTLO} = ops;
    rsdata = a; rtdata = b;
    stalls = 0; done_cyc = 0; dones = 0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      h = hi; l = lo;
      if (stall) stalls++;
      if (done) begin
        dones++; done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    {DIV, DIVU, MULTU, MTHI, MTLO} = 5'b0;
    #1;
  endtask

  task automatic test_arith_op(input string name, input logic [4:0] ops,
                               input logic [31:0] a, b, exp_h, exp_l, input int exp_st,
                               output int done_cyc);
    int stalls, dones, exp_dc;
    logic [31:0] h, l;
    run_op(ops, a, b, stalls, done_cyc, dones, h, l);
    exp_dc = (exp_st == 0) ? 0 : exp_st + 1;
    checks++;
    if (stalls !== exp_st) begin
      errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_st);
    end
    checks++;
    if (done_cyc !== exp_dc) begin
      errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_dc);
    end
    checks++;
    if (h !== exp_h) begin
      errors++; $display("FAIL %s hi got %h want %h", name, h, exp_h);
    end
    checks++;
    if (l !== exp_l) begin
      errors++; $display("FAIL %s lo got %h want %h", name, l, exp_l);
    end
    m_hi = exp_h; m_lo = exp_l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {DIV, DIVU, MULTU, MTHI, MTLO} = 5'b0;
    rsdata = 32'd0; rtdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, done} !== 2'b00) begin
      errors++; $display("FAIL reset stall/done got %b want 00", {stall, done});
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++; $display("FAIL reset hi/lo got %h want 0", {hi, lo});
    end
  endtask

  task automatic test_multu_max();
    int dc;
    test_arith_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 33, dc);
    go_idle();
    checks++;
    if ({stall, done} !== 2'b00) begin
      errors++; $display("FAIL multu_single_pulse stall/done got %b want 00", {stall, done});
    end
  endtask

  task automatic test_divide();
    int dc;
    test_arith_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, dc);
    go_idle();
    test_arith_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, dc);
    go_idle();
    test_arith_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0000_0000, 32'h8000_0000, 34, dc);
    go_idle();
    test_arith_op("divu_by_zero", OP_DIVU, 32'h1234_5678, 32'd0,
                  32'h1234_5678, 32'hFFFF_FFFF, 1, dc);
    go_idle();
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    @(negedge clk);
    {DIV, DIVU, MULTU, MTHI, MTLO} = OP_MTHI; rsdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL mthi_stall got %b want 0", stall);
    end
    @(negedge clk);
    {DIV, DIVU, MULTU, MTHI, MTLO} = OP_MTLO; rsdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if (hi !== 32'hDEAD_BEEF || stall !== 1'b0) begin
      errors++; $display("FAIL mthi_value hi got %h stall %b want deadbeef 0", hi, stall);
    end
    go_idle();
    checks++;
    if (lo !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mtlo_value lo got %h want 0badf00d", lo);
    end
    lo_before = 32'h0BAD_F00D;
    @(negedge clk);
    {DIV, DIVU, MULTU, MTHI, MTLO} = OP_MTHI | OP_MTLO; rsdata = 32'h5555_AAAA;
    go_idle();
    checks++;
    if (hi !== 32'h5555_AAAA || lo !== lo_before) begin
      errors++; $display("FAIL mthi_mtlo_priority hi %h lo %h want 5555aaaa %h", hi, lo, lo_before);
    end
    m_hi = 32'h5555_AAAA; m_lo = lo_before;
  endtask

  task automatic test_reset_mid_op();
    int dc;
    @(negedge clk);
    {DIV, DIVU, MULTU, MTHI, MTLO} = OP_MULTU; rsdata = 32'd3; rtdata = 32'd5;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    {DIV, DIVU, MULTU, MTHI, MTLO} = 5'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, done, hi, lo} !== 66'd0) begin
      errors++; $display("FAIL reset_mid_op stall %b done %b hi %h lo %h want all 0", stall, done, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    test_arith_op("multu_after_reset", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33, dc);
    go_idle();
  endtask

  task automatic test_back_to_back();
    int dc1, dc2;
    test_arith_op("b2b_divu", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33, dc1);
    test_arith_op("b2b_multu", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33, dc2);
    checks++;
    if (dc1 + dc2 !== 68) begin
      errors++; $display("FAIL b2b_second_done_cycle got %0d want 68", dc1 + dc2);
    end
    go_idle();
  endtask

  task automatic test_random();
    logic [4:0]  ops;
    logic [31:0] a, b, nh, nl;
    int st, dc;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) < 7) ops = 5'b00001 << $urandom_range(0, 4);
      else ops = 5'($urandom_range(1, 31));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model_op(ops, a, b, m_hi, m_lo, nh, nl, st);
      test_arith_op($sformatf("random_%0d_ops%b", i, ops), ops, a, b, nh, nl, st, dc);
      go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_divide();
    test_mthi_mtlo();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
